// File: rtl/elc3_ctrl_pkg.sv
// Shared eLC-3 control definitions: sequencer states, opcodes and datapath mux/function encodings.
package elc3_ctrl_pkg;

    typedef enum logic [4:0] {
        StHalted, StLoadPc, StFetch1, StFetch2, StFetch3, StDecode,
        StExec, StBrTake, StJmp, StJsr1, StJsr2, StLea,
        StMemAddr, StIndRead, StIndMar, StIndHold, StLdRead, StLdWb,
        StStMdr, StStWrite, StTrap1, StTrap2, StTrap3, StTrap4,
        StMulStart, StMulWait0, StMulWait, StMulWb, StPause1, StPause2
    } state_e;

    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpLd    = 4'b0010;
    localparam logic [3:0] OpSt    = 4'b0011;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpMul   = 4'b1000;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpLdi   = 4'b1010;
    localparam logic [3:0] OpSti   = 4'b1011;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;
    localparam logic [3:0] OpLea   = 4'b1110;
    localparam logic [3:0] OpTrap  = 4'b1111;

    localparam logic [1:0] AlukAdd   = 2'd0;
    localparam logic [1:0] AlukAnd   = 2'd1;
    localparam logic [1:0] AlukNot   = 2'd2;
    localparam logic [1:0] AlukPassA = 2'd3;

    localparam logic [1:0] PcmuxInc   = 2'd0;
    localparam logic [1:0] PcmuxBus   = 2'd1;
    localparam logic [1:0] PcmuxAdder = 2'd2;
    localparam logic [1:0] PcmuxIn    = 2'd3;

    localparam logic [1:0] DrmuxIr = 2'd0;
    localparam logic [1:0] DrmuxR7 = 2'd1;
    localparam logic [1:0] DrmuxR6 = 2'd2;

    localparam logic [1:0] Sr1muxIr119 = 2'd0;
    localparam logic [1:0] Sr1muxIr86  = 2'd1;

    localparam logic [1:0] Addr2Zero  = 2'd0;
    localparam logic [1:0] Addr2Off6  = 2'd1;
    localparam logic [1:0] Addr2Off9  = 2'd2;
    localparam logic [1:0] Addr2Off11 = 2'd3;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_mul, gate_alu, gate_marmux;
        logic       addr1mux, sr2mux, marmux, mio_en, mul_en;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux, aluk;
        logic       mem_oe, mem_we, halted;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts the cycles of one memory bus window; o_last marks the final cycle of the window.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    output logic o_last
);
    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] Preload = CntW'(MEM_WAIT - 1);

    logic [CntW-1:0] r_cnt;

    assign o_last = i_active && (r_cnt == '0);

    // Reloading on the last cycle lets two windows run back to back.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || o_last) begin
            r_cnt <= Preload;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// eLC-3 multi-cycle Moore control sequencer driving datapath loads, gates, muxes and SRAM strobes.
module control_unit
    import elc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_continue,
    input  logic [3:0] i_ir_15_12,
    input  logic       i_ir_5,
    input  logic       i_ir_11,
    input  logic       i_ben,
    input  logic       i_mul_r,
    output logic       o_ld_mar,
    output logic       o_ld_mdr,
    output logic       o_ld_ir,
    output logic       o_ld_ben,
    output logic       o_ld_reg,
    output logic       o_ld_cc,
    output logic       o_ld_pc,
    output logic       o_gate_pc,
    output logic       o_gate_mdr,
    output logic       o_gate_mul,
    output logic       o_gate_alu,
    output logic       o_gate_marmux,
    output logic       o_addr1mux,
    output logic       o_sr2mux,
    output logic       o_marmux,
    output logic       o_mio_en,
    output logic       o_mul_en,
    output logic [1:0] o_addr2mux,
    output logic [1:0] o_pcmux,
    output logic [1:0] o_drmux,
    output logic [1:0] o_sr1mux,
    output logic [1:0] o_aluk,
    output logic       o_mem_oe,
    output logic       o_mem_we,
    output logic       o_halted
);
    state_e r_state;
    state_e w_state_d;
    ctrl_t  w_ctrl;
    logic   w_last;
    logic   w_base_reg;

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (w_ctrl.mem_oe | w_ctrl.mem_we),
        .o_last   (w_last)
    );

    // LDR/STR form their address from a base register, the other memory ops from PC.
    assign w_base_reg = (i_ir_15_12 == OpLdr) || (i_ir_15_12 == OpStr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StHalted;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_ctrl    = '0;
        w_state_d = r_state;
        case (r_state)
            StHalted: begin
                w_ctrl.halted = 1'b1;
                if (i_run) w_state_d = StLoadPc;
            end
            StLoadPc: begin
                w_ctrl.ld_pc = 1'b1;
                w_ctrl.pcmux = PcmuxIn;
                w_state_d    = StFetch1;
            end
            StFetch1: begin
                w_ctrl.gate_pc = 1'b1;
                w_ctrl.ld_mar  = 1'b1;
                w_ctrl.ld_pc   = 1'b1;
                w_ctrl.pcmux   = PcmuxInc;
                w_state_d      = StFetch2;
            end
            StFetch2, StIndRead, StLdRead, StTrap3: begin
                w_ctrl.mem_oe = 1'b1;
                w_ctrl.mio_en = 1'b1;
                w_ctrl.ld_mdr = w_last;
                if (w_last) begin
                    unique case (r_state)
                        StFetch2:  w_state_d = StFetch3;
                        StIndRead: w_state_d = StIndMar;
                        StLdRead:  w_state_d = StLdWb;
                        default:   w_state_d = StTrap4;
                    endcase
                end
            end
            StFetch3: begin
                w_ctrl.gate_mdr = 1'b1;
                w_ctrl.ld_ir    = 1'b1;
                w_state_d       = StDecode;
            end
            StDecode: begin
                w_ctrl.ld_ben = 1'b1;
                case (i_ir_15_12)
                    OpAdd, OpAnd, OpNot:              w_state_d = StExec;
                    OpBr:                             w_state_d = i_ben ? StBrTake : StFetch1;
                    OpJmp:                            w_state_d = StJmp;
                    OpJsr:                            w_state_d = StJsr1;
                    OpLd, OpLdr, OpLdi, OpSt, OpStr,
                    OpSti:                            w_state_d = StMemAddr;
                    OpLea:                            w_state_d = StLea;
                    OpTrap:                           w_state_d = StTrap1;
                    OpMul:                            w_state_d = StMulStart;
                    OpPause:                          w_state_d = StPause1;
                    default:                          w_state_d = StFetch1;
                endcase
            end
            StExec: begin
                w_ctrl.sr1mux   = Sr1muxIr86;
                w_ctrl.sr2mux   = i_ir_5;
                w_ctrl.aluk     = (i_ir_15_12 == OpAnd) ? AlukAnd :
                                  (i_ir_15_12 == OpNot) ? AlukNot : AlukAdd;
                w_ctrl.gate_alu = 1'b1;
                w_ctrl.ld_reg   = 1'b1;
                w_ctrl.ld_cc    = 1'b1;
                w_ctrl.drmux    = DrmuxIr;
                w_state_d       = StFetch1;
            end
            StBrTake: begin
                w_ctrl.pcmux    = PcmuxAdder;
                w_ctrl.addr2mux = Addr2Off9;
                w_ctrl.ld_pc    = 1'b1;
                w_state_d       = StFetch1;
            end
            StJmp: begin
                w_ctrl.sr1mux   = Sr1muxIr86;
                w_ctrl.addr1mux = 1'b1;
                w_ctrl.addr2mux = Addr2Zero;
                w_ctrl.pcmux    = PcmuxAdder;
                w_ctrl.ld_pc    = 1'b1;
                w_state_d       = StFetch1;
            end
            StJsr1, StTrap1: begin
                w_ctrl.gate_pc = 1'b1;
                w_ctrl.drmux   = DrmuxR7;
                w_ctrl.ld_reg  = 1'b1;
                w_state_d      = (r_state == StJsr1) ? StJsr2 : StTrap2;
            end
            StJsr2: begin
                if (i_ir_11) begin
                    w_ctrl.addr2mux = Addr2Off11;
                end else begin
                    w_ctrl.sr1mux   = Sr1muxIr86;
                    w_ctrl.addr1mux = 1'b1;
                    w_ctrl.addr2mux = Addr2Zero;
                end
                w_ctrl.pcmux = PcmuxAdder;
                w_ctrl.ld_pc = 1'b1;
                w_state_d    = StFetch1;
            end
            StLea: begin
                w_ctrl.gate_marmux = 1'b1;
                w_ctrl.marmux      = 1'b1;
                w_ctrl.addr2mux    = Addr2Off9;
                w_ctrl.ld_reg      = 1'b1;
                w_ctrl.ld_cc       = 1'b1;
                w_state_d          = StFetch1;
            end
            StMemAddr: begin
                w_ctrl.gate_marmux = 1'b1;
                w_ctrl.marmux      = 1'b1;
                w_ctrl.ld_mar      = 1'b1;
                w_ctrl.sr1mux      = w_base_reg ? Sr1muxIr86 : Sr1muxIr119;
                w_ctrl.addr1mux    = w_base_reg;
                w_ctrl.addr2mux    = w_base_reg ? Addr2Off6 : Addr2Off9;
                if ((i_ir_15_12 == OpLdi) || (i_ir_15_12 == OpSti)) w_state_d = StIndRead;
                else if ((i_ir_15_12 == OpSt) || (i_ir_15_12 == OpStr)) w_state_d = StStMdr;
                else w_state_d = StLdRead;
            end
            StIndMar: begin
                w_ctrl.gate_mdr = 1'b1;
                w_ctrl.ld_mar   = 1'b1;
                w_state_d       = StIndHold;
            end
            // Idle cycle gives the freshly loaded pointer address full setup before the next access.
            StIndHold: w_state_d = (i_ir_15_12 == OpSti) ? StStMdr : StLdRead;
            StLdWb, StTrap4: begin
                w_ctrl.gate_mdr = 1'b1;
                w_ctrl.ld_reg   = (r_state == StLdWb);
                w_ctrl.ld_cc    = (r_state == StLdWb);
                w_ctrl.pcmux    = (r_state == StTrap4) ? PcmuxBus : PcmuxInc;
                w_ctrl.ld_pc    = (r_state == StTrap4);
                w_state_d       = StFetch1;
            end
            StStMdr: begin
                w_ctrl.sr1mux   = Sr1muxIr119;
                w_ctrl.aluk     = AlukPassA;
                w_ctrl.gate_alu = 1'b1;
                w_ctrl.ld_mdr   = 1'b1;
                w_state_d       = StStWrite;
            end
            StStWrite: begin
                w_ctrl.mem_we = 1'b1;
                if (w_last) w_state_d = StFetch1;
            end
            StTrap2: begin
                w_ctrl.gate_marmux = 1'b1;
                w_ctrl.ld_mar      = 1'b1;
                w_state_d          = StTrap3;
            end
            StMulStart: begin
                w_ctrl.mul_en = 1'b1;
                w_state_d     = StMulWait0;
            end
            // MUL_R may still be high from the previous multiply, so the first wait cycle ignores it.
            StMulWait0, StMulWait: begin
                w_ctrl.sr1mux = Sr1muxIr86;
                w_ctrl.sr2mux = i_ir_5;
                if (r_state == StMulWait0) w_state_d = StMulWait;
                else if (i_mul_r) w_state_d = StMulWb;
            end
            StMulWb: begin
                w_ctrl.gate_mul = 1'b1;
                w_ctrl.ld_reg   = 1'b1;
                w_ctrl.ld_cc    = 1'b1;
                w_ctrl.drmux    = DrmuxIr;
                w_state_d       = StFetch1;
            end
            StPause1: begin
                w_ctrl.halted = 1'b1;
                if (i_continue) w_state_d = StPause2;
            end
            StPause2: begin
                w_ctrl.halted = 1'b1;
                if (!i_continue) w_state_d = StFetch1;
            end
            default: w_state_d = StHalted;
        endcase
    end

    assign o_ld_mar      = w_ctrl.ld_mar;
    assign o_ld_mdr      = w_ctrl.ld_mdr;
    assign o_ld_ir       = w_ctrl.ld_ir;
    assign o_ld_ben      = w_ctrl.ld_ben;
    assign o_ld_reg      = w_ctrl.ld_reg;
    assign o_ld_cc       = w_ctrl.ld_cc;
    assign o_ld_pc       = w_ctrl.ld_pc;
    assign o_gate_pc     = w_ctrl.gate_pc;
    assign o_gate_mdr    = w_ctrl.gate_mdr;
    assign o_gate_mul    = w_ctrl.gate_mul;
    assign o_gate_alu    = w_ctrl.gate_alu;
    assign o_gate_marmux = w_ctrl.gate_marmux;
    assign o_addr1mux    = w_ctrl.addr1mux;
    assign o_sr2mux      = w_ctrl.sr2mux;
    assign o_marmux      = w_ctrl.marmux;
    assign o_mio_en      = w_ctrl.mio_en;
    assign o_mul_en      = w_ctrl.mul_en;
    assign o_addr2mux    = w_ctrl.addr2mux;
    assign o_pcmux       = w_ctrl.pcmux;
    assign o_drmux       = w_ctrl.drmux;
    assign o_sr1mux      = w_ctrl.sr1mux;
    assign o_aluk        = w_ctrl.aluk;
    assign o_mem_oe      = w_ctrl.mem_oe;
    assign o_mem_we      = w_ctrl.mem_we;
    assign o_halted      = w_ctrl.halted;

endmodule
